// File: rtl/eth_rx_wb_writer.sv
// Packs the received Ethernet byte stream into little-endian words, writes them
// to an SRAM packet buffer over Wishbone, then writes a length header at the base.
module eth_rx_wb_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BYTES  = 1536
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] buf_base,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  output logic        rx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        pkt_done,
  output logic [15:0] pkt_len,
  output logic        pkt_trunc,
  output logic        pkt_err,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_RX, S_FLUSH, S_HDR, S_DONE} state_t;

  state_t      state;
  logic        run_q;
  logic [29:0] base_q;
  logic [29:0] dadr_q;
  logic [15:0] byte_cnt;
  logic [31:0] word_q;
  logic        part_q;
  logic        trunc_q;
  logic        err_q;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;

  logic        acc;
  logic        start;
  logic        take;
  logic [15:0] cur_cnt;
  logic [1:0]  lane;
  logic        store;
  logic [31:0] new_word;
  logic        push;
  logic [31:0] push_data;
  logic        wb_done;
  logic        pop;
  logic        unused_base_lsbs;

  assign unused_base_lsbs = &{1'b0, buf_base[1:0]};
  assign dbg_state  = state;
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Handshake: a byte transfers on any clock edge where rx_valid && rx_ready.
  assign rx_ready = run_q && ((state == S_IDLE) || ((state == S_RX) && !fifo_full));
  assign acc      = rx_valid && rx_ready;
  assign start    = acc && (state == S_IDLE) && rx_sop;
  assign take     = start || (acc && (state == S_RX));
  assign cur_cnt  = start ? 16'd0 : byte_cnt;
  assign lane     = cur_cnt[1:0];
  assign store    = (32'(cur_cnt) < MAX_BYTES);
  assign wb_done  = wb_cyc_o && (wb_ack_i || wb_err_i);
  assign pop      = wb_done && (state != S_HDR);

  always_comb begin
    new_word = (lane == 2'd0) ? 32'h0 : word_q;
    new_word[{lane, 3'b000} +: 8] = rx_data;
  end

  // A partial word still has to go out when the stream ends past MAX_BYTES.
  assign push      = take && ((store && ((lane == 2'd3) || rx_eop)) ||
                              (!store && rx_eop && part_q));
  assign push_data = store ? new_word : word_q;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= S_IDLE;
      run_q     <= 1'b0;
      base_q    <= '0;
      dadr_q    <= '0;
      byte_cnt  <= '0;
      word_q    <= '0;
      part_q    <= 1'b0;
      trunc_q   <= 1'b0;
      err_q     <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_len   <= '0;
      pkt_trunc <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      wb_sel_o <= 4'hF;
      pkt_done <= 1'b0;

      if (wb_cyc_o && wb_err_i) err_q <= 1'b1;

      if (start) begin
        base_q  <= buf_base[31:2];
        dadr_q  <= buf_base[31:2] + 30'd1;
        trunc_q <= 1'b0;
        err_q   <= 1'b0;
      end

      if (take) begin
        byte_cnt <= (cur_cnt == 16'hFFFF) ? cur_cnt : cur_cnt + 16'd1;
        if (store) begin
          word_q <= new_word;
          part_q <= !((lane == 2'd3) || rx_eop);
        end else begin
          trunc_q <= 1'b1;
          if (rx_eop) part_q <= 1'b0;
        end
      end

      // Data master: one single write per FIFO word, idle cycle after each.
      if (wb_done) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        if (state != S_HDR) dadr_q <= dadr_q + 30'd1;
      end else if (!wb_cyc_o && !fifo_empty && (state != S_HDR)) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= 1'b1;
        wb_adr_o <= {dadr_q, 2'b00};
        wb_dat_o <= mem[rd_ptr];
      end

      case (state)
        S_IDLE:  if (start) state <= rx_eop ? S_FLUSH : S_RX;
        S_RX:    if (acc && rx_eop) state <= S_FLUSH;
        S_FLUSH: if (fifo_empty && !wb_cyc_o) state <= S_HDR;
        S_HDR: begin
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= {base_q, 2'b00};
            wb_dat_o <= {16'h0, byte_cnt};
          end else if (wb_done) begin
            state     <= S_DONE;
            pkt_done  <= 1'b1;
            pkt_len   <= byte_cnt;
            pkt_trunc <= trunc_q;
            pkt_err   <= err_q | wb_err_i;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_wb_writer.sv
// Directed bench for eth_rx_wb_writer with a variable-latency Wishbone slave
// and queue-based scoreboards for memory writes and packet completions.
module tb_eth_rx_wb_writer;

  localparam int FD = 4;
  localparam int MB = 1536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] buf_base = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic        rx_ready;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic        pkt_trunc;
  logic        pkt_err;
  logic [2:0]  dbg_state;

  eth_rx_wb_writer #(.FIFO_DEPTH(FD), .MAX_BYTES(MB)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .buf_base (buf_base),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_sop   (rx_sop),
    .rx_eop   (rx_eop),
    .rx_ready (rx_ready),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .pkt_done (pkt_done),
    .pkt_len  (pkt_len),
    .pkt_trunc(pkt_trunc),
    .pkt_err  (pkt_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lat = 5;
  int wr_idx = 0;
  int err_idx = -1;
  int scnt = 0;
  bit saw_bp = 1'b0;

  logic [63:0] exp_q[$];
  logic [17:0] pkt_q[$];
  logic [7:0]  pkt_bytes[$];
  logic [63:0] mon_e;
  logic [17:0] mon_p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: acks (or errs) after lat cycles of strobe, one cycle wide
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      scnt     <= 0;
    end else if (wb_ack_i || wb_err_i) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      scnt     <= 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (scnt >= lat - 1) begin
        if (wr_idx == err_idx) wb_err_i <= 1'b1;
        else                   wb_ack_i <= 1'b1;
        wr_idx <= wr_idx + 1;
        scnt   <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && !rx_ready) saw_bp = 1'b1;
      if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexp_write obs=%h:%h exp=none", wb_adr_o, wb_dat_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_adr", 64'(wb_adr_o), 64'(mon_e[63:32]));
          chk("wr_dat", 64'(wb_dat_o), 64'(mon_e[31:0]));
          chk("wr_sel", 64'(wb_sel_o), 64'h0F);
          chk("wr_we_stb", 64'({wb_we_o, wb_stb_o}), 64'h3);
        end
      end
      if (pkt_done) begin
        if (pkt_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexp_pkt_done obs=len %0d exp=none", pkt_len);
        end else begin
          mon_p = pkt_q.pop_front();
          chk("pkt_len", 64'(pkt_len), 64'(mon_p[17:2]));
          chk("pkt_trunc", 64'(pkt_trunc), 64'(mon_p[1]));
          chk("pkt_err", 64'(pkt_err), 64'(mon_p[0]));
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop);
    int guard = 0;
    @(negedge clk);
    rx_data = d; rx_valid = 1'b1; rx_sop = sop; rx_eop = eop;
    while (!rx_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      total++;
      bad++;
      $error("FAIL rx_ready_timeout obs=%0d exp=<5000", guard);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    pkt_bytes.delete();
    for (int i = 0; i < n; i++) pkt_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference packing: stored bytes into LE words at base+4+4k, then header.
  task automatic expect_pkt(input logic [31:0] base, input bit perr);
    logic [31:0] b;
    logic [31:0] w;
    int n;
    int stored;
    n = pkt_bytes.size();
    b = base & 32'hFFFF_FFFC;
    stored = (n < MB) ? n : MB;
    for (int wi = 0; wi < (stored + 3) / 4; wi++) begin
      w = '0;
      for (int l = 0; l < 4; l++)
        if (wi * 4 + l < stored) w[8*l +: 8] = pkt_bytes[wi * 4 + l];
      exp_q.push_back({b + 32'(4 + 4 * wi), w});
    end
    exp_q.push_back({b, 16'h0, 16'(n)});
    pkt_q.push_back({16'(n), (n > MB), perr});
  endtask

  task automatic send_pkt(input logic [31:0] base);
    int n;
    n = pkt_bytes.size();
    buf_base = base;
    for (int i = 0; i < n; i++) begin
      send_byte(pkt_bytes[i], (i == 0), (i == n - 1));
      if (i == 0) buf_base = $urandom;
    end
  endtask

  task automatic wait_idle(input int bound);
    int g = 0;
    while ((exp_q.size() != 0 || pkt_q.size() != 0) && g < bound) begin
      @(negedge clk);
      g++;
    end
    if (g >= bound) begin
      total++;
      bad++;
      $error("FAIL drain_timeout obs=%0d/%0d exp=0/0", exp_q.size(), pkt_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc_stb_we", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'h0);
    chk("rst_adr", 64'(wb_adr_o), 64'h0);
    chk("rst_dat", 64'(wb_dat_o), 64'h0);
    chk("rst_sel", 64'(wb_sel_o), 64'h0);
    chk("rst_rx_ready", 64'(rx_ready), 64'h0);
    chk("rst_pkt", 64'({pkt_done, pkt_len, pkt_trunc, pkt_err}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6-byte packet with first-request latency check
    lat = 5;
    pkt_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    expect_pkt(32'h100, 1'b0);
    buf_base = 32'h100;
    send_byte(8'hDE, 1'b1, 1'b0);
    buf_base = 32'h0BAD_0000;
    send_byte(8'hAD, 1'b0, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0);
    send_byte(8'hEF, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_cyc_low", 64'(wb_cyc_o), 64'h0);
    @(negedge clk);
    chk("lat_cyc_high", 64'(wb_cyc_o), 64'h1);
    chk("lat_adr", 64'(wb_adr_o), 64'h104);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b1);
    wait_idle(2000);

    // 64 back-to-back bytes into a slow slave
    lat = 12;
    saw_bp = 1'b0;
    fill_rand(64);
    expect_pkt(32'h400, 1'b0);
    send_pkt(32'h400);
    wait_idle(5000);
    chk("backpressure_seen", 64'(saw_bp), 64'h1);

    // 1600 bytes: truncated at MAX_BYTES
    lat = 2;
    fill_rand(1600);
    expect_pkt(32'h8000, 1'b0);
    send_pkt(32'h8000);
    wait_idle(20000);

    // bytes before sop are ignored, then a single-byte packet
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    pkt_bytes = '{8'h5A};
    expect_pkt(32'h2000, 1'b0);
    send_pkt(32'h2000);
    wait_idle(2000);

    // error on the second data write, unaligned base
    lat = 3;
    err_idx = wr_idx + 1;
    fill_rand(12);
    expect_pkt(32'h3001, 1'b1);
    send_pkt(32'h3001);
    wait_idle(2000);
    err_idx = -1;

    // reset while a cycle is in flight
    lat = 5;
    fill_rand(16);
    expect_pkt(32'h5000, 1'b0);
    buf_base = 32'h5000;
    for (int i = 0; i < 8; i++) send_byte(pkt_bytes[i], (i == 0), 1'b0);
    begin
      int g = 0;
      while (!wb_cyc_o && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("mid_cyc_seen", 64'(wb_cyc_o), 64'h1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'h0);
    chk("async_rst_rx_ready", 64'(rx_ready), 64'h0);
    exp_q.delete();
    pkt_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // next packet after reset completes normally
    fill_rand(10);
    expect_pkt(32'h6000, 1'b0);
    send_pkt(32'h6000);
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
